ros2_eth_rx_adapter: RTL and testbench

- Receive-side counterpart to the ROS2 Ethernet TX adapter.
- Accepts a decoded IP header (valid/ready, field-wise) and an AXI-Stream byte payload from the IP stack.
- Re-serialises the header as 20 big-endian bytes, followed by the payload, into the byte FIFO feeding the ROS2 core (HLS ap_fifo write side: data/full_n/wr_en).
- Flags length mismatches.

---
 rtl/ros2_eth_rx_adapter_pkg.sv | 48 ++++
 rtl/ros2_eth_rx_adapter_hdr_serializer.sv | 37 +++
 rtl/ros2_eth_rx_adapter.sv | 163 ++++++++++++++++
 tb/tb_ros2_eth_rx_adapter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ros2_eth_rx_adapter_pkg.sv
// Shared IP header constants, field struct and FSM encodings for the ROS2 Ethernet RX adapter.
// ROS2_ETH_RX_PROTO_FILTER_EN adds the DROP state used by the protocol filter.
package ros2_eth_rx_adapter_pkg;

    localparam int         IP_HDR_SIZE            = 20;
    localparam logic [4:0] IP_HDR_OFFSET_TOS      = 5'd1;
    localparam logic [4:0] IP_HDR_OFFSET_TOT_LEN  = 5'd2;
    localparam logic [4:0] IP_HDR_OFFSET_ID       = 5'd4;
    localparam logic [4:0] IP_HDR_OFFSET_FRAG_OFF = 5'd6;
    localparam logic [4:0] IP_HDR_OFFSET_TTL      = 5'd8;
    localparam logic [4:0] IP_HDR_OFFSET_PROTOCOL = 5'd9;
    localparam logic [4:0] IP_HDR_OFFSET_CHECK    = 5'd10;
    localparam logic [4:0] IP_HDR_OFFSET_SADDR    = 5'd12;
    localparam logic [4:0] IP_HDR_OFFSET_DADDR    = 5'd16;
    localparam logic [7:0] IP_PROTO_UDP           = 8'd17;

`ifdef ROS2_ETH_RX_PROTO_FILTER_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;
`endif

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] length;
        logic [15:0] identification;
        logic [2:0]  flags;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] source_ip;
        logic [31:0] dest_ip;
    } ip_hdr_t;

endpackage

// File: rtl/ros2_eth_rx_adapter_hdr_serializer.sv
// Combinational big-endian byte picker over a latched IP header.
module ros2_ip_hdr_serializer
    import ros2_eth_rx_adapter_pkg::*;
(
    input  ip_hdr_t    i_hdr,
    input  logic [4:0] i_offset,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_offset)
            5'd0:                          o_byte = {i_hdr.version, i_hdr.ihl};
            IP_HDR_OFFSET_TOS:             o_byte = {i_hdr.dscp, i_hdr.ecn};
            IP_HDR_OFFSET_TOT_LEN:         o_byte = i_hdr.length[15:8];
            IP_HDR_OFFSET_TOT_LEN + 5'd1:  o_byte = i_hdr.length[7:0];
            IP_HDR_OFFSET_ID:              o_byte = i_hdr.identification[15:8];
            IP_HDR_OFFSET_ID + 5'd1:       o_byte = i_hdr.identification[7:0];
            IP_HDR_OFFSET_FRAG_OFF:        o_byte = {i_hdr.flags, i_hdr.frag_offset[12:8]};
            IP_HDR_OFFSET_FRAG_OFF + 5'd1: o_byte = i_hdr.frag_offset[7:0];
            IP_HDR_OFFSET_TTL:             o_byte = i_hdr.ttl;
            IP_HDR_OFFSET_PROTOCOL:        o_byte = i_hdr.protocol;
            IP_HDR_OFFSET_CHECK:           o_byte = i_hdr.checksum[15:8];
            IP_HDR_OFFSET_CHECK + 5'd1:    o_byte = i_hdr.checksum[7:0];
            IP_HDR_OFFSET_SADDR:           o_byte = i_hdr.source_ip[31:24];
            IP_HDR_OFFSET_SADDR + 5'd1:    o_byte = i_hdr.source_ip[23:16];
            IP_HDR_OFFSET_SADDR + 5'd2:    o_byte = i_hdr.source_ip[15:8];
            IP_HDR_OFFSET_SADDR + 5'd3:    o_byte = i_hdr.source_ip[7:0];
            IP_HDR_OFFSET_DADDR:           o_byte = i_hdr.dest_ip[31:24];
            IP_HDR_OFFSET_DADDR + 5'd1:    o_byte = i_hdr.dest_ip[23:16];
            IP_HDR_OFFSET_DADDR + 5'd2:    o_byte = i_hdr.dest_ip[15:8];
            IP_HDR_OFFSET_DADDR + 5'd3:    o_byte = i_hdr.dest_ip[7:0];
            default:                       o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ros2_eth_rx_adapter.sv
// Re-serialises a decoded IP header plus AXI-Stream payload into the ROS2 core byte FIFO.
// Define ROS2_ETH_RX_PROTO_FILTER_EN to drop packets whose protocol differs from FILTER_PROTO.
module ros2_eth_rx_adapter
    import ros2_eth_rx_adapter_pkg::*;
#(
    parameter logic [7:0] FILTER_PROTO = IP_PROTO_UDP
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_rx_hdr_valid,
    output logic        o_rx_hdr_ready,
    input  logic [3:0]  i_rx_ip_version,
    input  logic [3:0]  i_rx_ip_ihl,
    input  logic [5:0]  i_rx_ip_dscp,
    input  logic [1:0]  i_rx_ip_ecn,
    input  logic [15:0] i_rx_ip_length,
    input  logic [15:0] i_rx_ip_identification,
    input  logic [2:0]  i_rx_ip_flags,
    input  logic [12:0] i_rx_ip_fragment_offset,
    input  logic [7:0]  i_rx_ip_ttl,
    input  logic [7:0]  i_rx_ip_protocol,
    input  logic [15:0] i_rx_ip_header_checksum,
    input  logic [31:0] i_rx_ip_source_ip,
    input  logic [31:0] i_rx_ip_dest_ip,
    input  logic        i_rx_payload_tvalid,
    output logic        o_rx_payload_tready,
    input  logic [7:0]  i_rx_payload_tdata,
    input  logic        i_rx_payload_tlast,
    output logic [7:0]  o_dout_data,
    input  logic        i_dout_full_n,
    output logic        o_dout_wr_en,
    output logic        o_len_err
);

    state_t      r_state;
    state_t      w_state_next;
    ip_hdr_t     r_hdr;
    ip_hdr_t     w_hdr_in;
    logic [4:0]  r_offset;
    logic [15:0] r_count;
    logic        r_len_err;
    logic [7:0]  w_hdr_byte;
    logic        w_hdr_fire;
    logic        w_hdr_write;
    logic        w_pay_beat;
    logic        w_drop;
    logic [15:0] w_count_next;
    logic [15:0] w_expected;
    logic        w_len_bad;

    assign w_hdr_in = '{
        version:        i_rx_ip_version,
        ihl:            i_rx_ip_ihl,
        dscp:           i_rx_ip_dscp,
        ecn:            i_rx_ip_ecn,
        length:         i_rx_ip_length,
        identification: i_rx_ip_identification,
        flags:          i_rx_ip_flags,
        frag_offset:    i_rx_ip_fragment_offset,
        ttl:            i_rx_ip_ttl,
        protocol:       i_rx_ip_protocol,
        checksum:       i_rx_ip_header_checksum,
        source_ip:      i_rx_ip_source_ip,
        dest_ip:        i_rx_ip_dest_ip
    };

`ifdef ROS2_ETH_RX_PROTO_FILTER_EN
    assign w_drop = (i_rx_ip_protocol != FILTER_PROTO);
`else
    assign w_drop = 1'b0;
`endif

    assign w_hdr_fire   = (r_state == ST_IDLE) && i_enable && i_rx_hdr_valid;
    assign w_hdr_write  = (r_state == ST_HDR) && i_dout_full_n;
    assign w_pay_beat   = (r_state == ST_PAYLOAD) && i_rx_payload_tvalid && i_dout_full_n;
    assign w_count_next = r_count + 16'd1;
    // Expected payload size wraps modulo 16 bits; a sub-20 length is always an error.
    assign w_expected   = r_hdr.length - 16'(IP_HDR_SIZE);
    assign w_len_bad    = (w_count_next != w_expected) || (r_hdr.length < 16'(IP_HDR_SIZE));

    ros2_ip_hdr_serializer u_hdr_serializer (
        .i_hdr    (r_hdr),
        .i_offset (r_offset),
        .o_byte   (w_hdr_byte)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_hdr     <= '0;
            r_offset  <= '0;
            r_count   <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_len_err <= 1'b0;
            if (w_hdr_fire) begin
                r_hdr    <= w_hdr_in;
                r_offset <= '0;
                r_count  <= '0;
            end
            if (w_hdr_write) begin
                r_offset <= r_offset + 5'd1;
            end
            if (w_pay_beat) begin
                r_count <= w_count_next;
                if (i_rx_payload_tlast) begin
                    r_len_err <= w_len_bad;
                end
            end
        end
    end

    assign o_len_err = r_len_err;

    // Outputs are forced low while reset is held so the FIFO never sees a stray write.
    always_comb begin
        w_state_next        = r_state;
        o_rx_hdr_ready      = 1'b0;
        o_rx_payload_tready = 1'b0;
        o_dout_wr_en        = 1'b0;
        o_dout_data         = 8'h00;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    o_rx_hdr_ready = i_enable;
                    if (w_hdr_fire) begin
                        w_state_next = w_drop ? state_t'(2'd3) : ST_HDR;
                    end
                end
                ST_HDR: begin
                    o_dout_data  = w_hdr_byte;
                    o_dout_wr_en = i_dout_full_n;
                    if (w_hdr_write && (r_offset == 5'(IP_HDR_SIZE - 1))) begin
                        w_state_next = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    o_rx_payload_tready = i_dout_full_n;
                    o_dout_data         = i_rx_payload_tdata;
                    o_dout_wr_en        = i_rx_payload_tvalid && i_dout_full_n;
                    if (w_pay_beat && i_rx_payload_tlast) begin
                        w_state_next = ST_IDLE;
                    end
                end
`ifdef ROS2_ETH_RX_PROTO_FILTER_EN
                ST_DROP: begin
                    o_rx_payload_tready = 1'b1;
                    if (i_rx_payload_tvalid && i_rx_payload_tlast) begin
                        w_state_next = ST_IDLE;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ros2_eth_rx_adapter.sv
// Randomised self-checking bench for ros2_eth_rx_adapter with a byte-stream scoreboard.
// Honours ROS2_ETH_RX_PROTO_FILTER_EN when the design is built with the protocol filter.
`timescale 1ns/1ps
module tb_ros2_eth_rx_adapter;

    typedef struct packed {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] len;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       hdrValid;
    logic       hdrReady;
    hdr_t       hdr;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic [7:0] doutData;
    logic       fullN;
    logic       wrEn;
    logic       lenErr;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] expQ[$];
    bit         errQ[$];
    logic [7:0] wrLog[$];
    logic [7:0] payload[$];
    int         lenErrPulses = 0;
    int         fullMode = 0;
    bit         inDrop = 1'b0;
    bit         prevLastBeat = 1'b0;
    bit         prevErr = 1'b0;

    always #5 clk = ~clk;

    ros2_eth_rx_adapter dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_enable                (enable),
        .i_rx_hdr_valid          (hdrValid),
        .o_rx_hdr_ready          (hdrReady),
        .i_rx_ip_version         (hdr.ver),
        .i_rx_ip_ihl             (hdr.ihl),
        .i_rx_ip_dscp            (hdr.dscp),
        .i_rx_ip_ecn             (hdr.ecn),
        .i_rx_ip_length          (hdr.len),
        .i_rx_ip_identification  (hdr.id),
        .i_rx_ip_flags           (hdr.flags),
        .i_rx_ip_fragment_offset (hdr.frag),
        .i_rx_ip_ttl             (hdr.ttl),
        .i_rx_ip_protocol        (hdr.proto),
        .i_rx_ip_header_checksum (hdr.csum),
        .i_rx_ip_source_ip       (hdr.src),
        .i_rx_ip_dest_ip         (hdr.dst),
        .i_rx_payload_tvalid     (tvalid),
        .o_rx_payload_tready     (tready),
        .i_rx_payload_tdata      (tdata),
        .i_rx_payload_tlast      (tlast),
        .o_dout_data             (doutData),
        .i_dout_full_n           (fullN),
        .o_dout_wr_en            (wrEn),
        .o_len_err               (lenErr)
    );

    // The header on the wire is simply the field concatenation read out MSB first.
    function automatic logic [7:0] hdrByte(input hdr_t h, input int idx);
        logic [159:0] v;
        v = h;
        return v[159 - 8*idx -: 8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: bound expired, expected a handshake at %0t", name, $time);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fullN = 1'b1;
        forever begin
            nextCycle();
            case (fullMode)
                0:       fullN = 1'b1;
                1:       fullN = ~fullN;
                default: fullN = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: every write is scored against the expected byte stream, every cycle for len_err.
    initial begin
        bit curBeat;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("resetOutputs", {20'd0, hdrReady, tready, wrEn, lenErr, doutData}, 32'd0);
                prevLastBeat = 1'b0;
            end else begin
                if (wrEn) begin
                    wrLog.push_back(doutData);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedWrite", {24'd0, doutData}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("fifoByte", {24'd0, doutData}, {24'd0, expQ.pop_front()});
                    end
                    checkOutput("writeWhileFull", {31'd0, fullN}, 32'd1);
                end
                checkOutput("lenErr", {31'd0, lenErr}, {31'd0, prevLastBeat & prevErr});
                if (lenErr) lenErrPulses++;
                if (inDrop) begin
                    checkOutput("dropTready", {30'd0, tready, wrEn}, 32'd2);
                end else begin
                    checkOutput("treadyWhileFull", {31'd0, tready & ~fullN}, 32'd0);
                end
                checkOutput("phaseOverlap", {31'd0, hdrReady & tready}, 32'd0);
                curBeat = tvalid & tready & tlast;
                if (curBeat) begin
                    if (errQ.size() == 0) begin
                        checkOutput("unexpectedLast", 32'd1, 32'd0);
                        prevErr = 1'b0;
                    end else begin
                        prevErr = errQ.pop_front();
                    end
                end
                prevLastBeat = curBeat;
            end
        end
    end

    task automatic applyStimulus(input hdr_t h, input int n, input bit gaps, input int disableAt);
        bit          drop;
        bit          err;
        int          waitCount;
        logic [15:0] expLen;
        drop = 1'b0;
`ifdef ROS2_ETH_RX_PROTO_FILTER_EN
        drop = (h.proto != 8'd17);
`endif
        expLen = h.len - 16'd20;
        err = drop ? 1'b0 : ((16'(n) != expLen) || (h.len < 16'd20));
        if (!drop) begin
            for (int i = 0; i < 20; i++) expQ.push_back(hdrByte(h, i));
            for (int i = 0; i < n; i++) expQ.push_back(payload[i]);
        end
        errQ.push_back(err);
        hdr = h;
        hdrValid = 1'b1;
        waitCount = 0;
        do begin
            @(negedge clk);
            waitCount++;
        end while (!hdrReady && waitCount < 200);
        if (waitCount >= 200) failNow("hdrHandshake");
        nextCycle();
        hdrValid = 1'b0;
        hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
        inDrop = drop;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    tvalid = 1'b0;
                    nextCycle();
                end
            end
            tvalid = 1'b1;
            tdata  = payload[i];
            tlast  = (i == n - 1);
            if (i == disableAt) enable = 1'b0;
            waitCount = 0;
            do begin
                @(negedge clk);
                waitCount++;
            end while (!tready && waitCount < 200);
            if (waitCount >= 200) failNow("payloadHandshake");
            nextCycle();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        inDrop = 1'b0;
    endtask

    function automatic hdr_t planHeader(input logic [15:0] len, input logic [7:0] proto);
        hdr_t h;
        h = '0;
        h.ver   = 4'd4;
        h.ihl   = 4'd5;
        h.len   = len;
        h.ttl   = 8'd64;
        h.proto = proto;
        h.csum  = 16'h1234;
        h.src   = 32'hC0A8_0001;
        h.dst   = 32'hC0A8_0002;
        return h;
    endfunction

    task automatic fillPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'(i + 1));
    endtask

    task automatic startTest();
        wrLog.delete();
        lenErrPulses = 0;
    endtask

    task automatic pinPlanBytes(input string name);
        checkOutput({name, "Count"}, wrLog.size(), 28);
        if (wrLog.size() == 28) begin
            checkOutput({name, "B0"},  {24'd0, wrLog[0]},  32'h45);
            checkOutput({name, "B3"},  {24'd0, wrLog[3]},  32'h1C);
            checkOutput({name, "B8"},  {24'd0, wrLog[8]},  32'h40);
            checkOutput({name, "B9"},  {24'd0, wrLog[9]},  32'h11);
            checkOutput({name, "B10"}, {24'd0, wrLog[10]}, 32'h12);
            checkOutput({name, "B12"}, {24'd0, wrLog[12]}, 32'hC0);
            checkOutput({name, "B15"}, {24'd0, wrLog[15]}, 32'h01);
            checkOutput({name, "B19"}, {24'd0, wrLog[19]}, 32'h02);
            checkOutput({name, "B20"}, {24'd0, wrLog[20]}, 32'h01);
            checkOutput({name, "B27"}, {24'd0, wrLog[27]}, 32'h08);
        end
    endtask

    initial begin
        hdr_t h;
        int   n;
        rst = 1'b1;
        enable = 1'b0;
        hdrValid = 1'b0;
        hdr = '0;
        tvalid = 1'b0;
        tdata = 8'h00;
        tlast = 1'b0;
        repeat (3) nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleDisabled", {21'd0, hdrReady, tready, wrEn, lenErr, doutData}, 32'd0);
        nextCycle();
        enable = 1'b1;

        $display("[TB] basic packet");
        startTest();
        fillPayload(8);
        applyStimulus(planHeader(16'h001C, 8'd17), 8, 1'b0, -1);
        repeat (3) nextCycle();
        pinPlanBytes("basic");
        checkOutput("basicLenErr", lenErrPulses, 0);

        $display("[TB] full_n toggling");
        fullMode = 1;
        startTest();
        applyStimulus(planHeader(16'h001C, 8'd17), 8, 1'b0, -1);
        repeat (3) nextCycle();
        pinPlanBytes("toggle");
        fullMode = 0;

        $display("[TB] short payload");
        startTest();
        fillPayload(6);
        applyStimulus(planHeader(16'h001C, 8'd17), 6, 1'b0, -1);
        repeat (3) nextCycle();
        checkOutput("shortCount", wrLog.size(), 26);
        checkOutput("shortLenErr", lenErrPulses, 1);

        $display("[TB] length below header size");
        startTest();
        fillPayload(1);
        applyStimulus(planHeader(16'h0010, 8'd17), 1, 1'b0, -1);
        repeat (3) nextCycle();
        checkOutput("tinyCount", wrLog.size(), 21);
        checkOutput("tinyLenErr", lenErrPulses, 1);

        $display("[TB] enable dropped mid-payload");
        startTest();
        fillPayload(8);
        applyStimulus(planHeader(16'h001C, 8'd17), 8, 1'b0, 2);
        hdrValid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hdrReadyDisabled", {31'd0, hdrReady}, 32'd0);
            nextCycle();
        end
        hdrValid = 1'b0;
        checkOutput("disableCount", wrLog.size(), 28);
        enable = 1'b1;

        $display("[TB] reset during header");
        h = planHeader(16'h001C, 8'd17);
        for (int i = 0; i < 20; i++) expQ.push_back(hdrByte(h, i));
        hdr = h;
        hdrValid = 1'b1;
        @(negedge clk);
        nextCycle();
        hdrValid = 1'b0;
        repeat (5) nextCycle();
        rst = 1'b1;
        nextCycle();
        expQ.delete();
        errQ.delete();
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("afterResetOutputs", {21'd0, hdrReady, tready, wrEn, lenErr, doutData}, 32'd0);
        nextCycle();
        enable = 1'b1;
        @(negedge clk);
        checkOutput("afterResetIdle", {30'd0, hdrReady, wrEn}, 32'd2);
        nextCycle();

`ifdef ROS2_ETH_RX_PROTO_FILTER_EN
        $display("[TB] protocol filter");
        startTest();
        fillPayload(8);
        applyStimulus(planHeader(16'h001C, 8'd6), 8, 1'b0, -1);
        repeat (3) nextCycle();
        checkOutput("dropCount", wrLog.size(), 0);
        checkOutput("dropLenErr", lenErrPulses, 0);
        startTest();
        applyStimulus(planHeader(16'h001C, 8'd17), 8, 1'b0, -1);
        repeat (3) nextCycle();
        pinPlanBytes("afterDrop");
`endif

        $display("[TB] randomised packets");
        fullMode = 2;
        for (int p = 0; p < 40; p++) begin
            h = {$urandom, $urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 3) != 0) h.len = 16'(20 + n);
            else h.len = 16'($urandom_range(0, 40));
            h.proto = ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd17;
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            applyStimulus(h, n, 1'b1, -1);
        end
        fullMode = 0;
        repeat (5) nextCycle();
        checkOutput("leftoverBytes", expQ.size(), 0);
        checkOutput("leftoverPackets", errQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
